// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory target on the CPU data bus.
// Word-organised RAM with byte/halfword/word stores and sign/zero-extended
// loads. Read data is registered and presented WAIT_STATES+1 cycles after
// acceptance; misaligned and out-of-range accesses are flagged and suppressed.
//
// Handshake: a request is a level on bus_read/bus_write. It is accepted on the
// rising edge where busy=0 and the FSM is in IDLE or RESP. While busy=1 the
// request is ignored and the core keeps holding the strobe. Completion is
// signalled by single-cycle pulses (rvalid for loads, misaligned/range_err for
// either kind) during the RESP cycle.
module data_bus_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        misaligned,
  output logic        range_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state;
  state_t state_nxt;

  logic [31:0] mem [DEPTH];

  logic [3:0]  wait_cnt;
  logic        pend_read;
  logic        pend_mis;
  logic        pend_rerr;
  logic [31:0] pend_data;

  logic                  req;
  logic                  accept;
  logic                  is_load;
  logic [29:0]           word_off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  mis;
  logic                  ok_access;
  logic                  store_en;
  logic [3:0]            byte_en;
  logic [31:0]           wlane;
  logic [31:0]           word_rd;
  logic [31:0]           shifted;
  logic [31:0]           load_val;

  // Request decode: a store wins when both strobes are raised.
  assign req       = bus_read | bus_write;
  assign is_load   = bus_read & ~bus_write;
  assign word_off  = addr[31:2] - BASE_ADDR[31:2];
  assign in_range  = word_off < 30'(DEPTH);
  assign idx       = word_off[ADDR_WIDTH-1:0];
  assign is_byte   = (funct3[1:0] == 2'b00);
  assign is_half   = (funct3[1:0] == 2'b01);
  assign is_word   = ~is_byte & ~is_half;  // 010 plus undefined encodings
  assign mis       = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign ok_access = in_range & ~mis;
  assign store_en  = accept & bus_write & ok_access;
  assign state_dbg = state;

  // Store lane steering: replicate the right-aligned data and pick byte enables.
  always_comb begin
    byte_en = 4'b1111;
    wlane   = wdata;
    if (is_byte) begin
      byte_en = 4'b0001 << addr[1:0];
      wlane   = {4{wdata[7:0]}};
    end else if (is_half) begin
      byte_en = addr[1] ? 4'b1100 : 4'b0011;
      wlane   = {2{wdata[15:0]}};
    end
  end

  // Load extraction: shift the addressed lane down, then extend by size/sign.
  always_comb begin
    word_rd  = mem[idx];
    shifted  = word_rd >> {addr[1:0], 3'b000};
    load_val = word_rd;
    if (is_byte) begin
      load_val = funct3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_val = funct3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end
    if (!ok_access) load_val = 32'd0;
  end

  // RAM write port: stores commit at the acceptance edge, contents never reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state, acceptance and response pulses.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        if (req) begin
          accept    = 1'b1;
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    rvalid     = (state == S_RESP) & pend_read;
    misaligned = (state == S_RESP) & pend_mis;
    range_err  = (state == S_RESP) & pend_rerr;
  end

  // Pending-access bookkeeping, wait countdown and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      pend_read <= 1'b0;
      pend_mis  <= 1'b0;
      pend_rerr <= 1'b0;
      pend_data <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      if (accept) begin
        pend_read <= is_load;
        pend_mis  <= mis;
        pend_rerr <= ~in_range;
        pend_data <= load_val;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (accept && WAIT_STATES == 0 && is_load) begin
        rdata <= load_val;
      end else if (state == S_WAIT && wait_cnt == 4'd0 && pend_read) begin
        rdata <= pend_data;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: one instance with no wait states,
// one with two wait states, sharing clock and address/data/funct3.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  funct3 = 3'd0;

  logic        rst0 = 1'b1, rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] rdata0;
  logic        rvalid0, busy0, mis0, rerr0;
  logic [1:0]  st0;

  logic        rst2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0;
  logic [31:0] rdata2;
  logic        rvalid2, busy2, mis2, rerr2;
  logic [1:0]  st2;

  int total = 0;
  int bad   = 0;
  logic seen;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  // Clock.
  always #5 clk = ~clk;

  data_bus_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst0), .bus_read(rd0), .bus_write(wr0), .addr(addr),
    .wdata(wdata), .funct3(funct3), .rdata(rdata0), .rvalid(rvalid0),
    .busy(busy0), .misaligned(mis0), .range_err(rerr0), .state_dbg(st0)
  );

  data_bus_responder #(.WAIT_STATES(2)) u2 (
    .clk(clk), .reset(rst2), .bus_read(rd2), .bus_write(wr2), .addr(addr),
    .wdata(wdata), .funct3(funct3), .rdata(rdata2), .rvalid(rvalid2),
    .busy(busy2), .misaligned(mis2), .range_err(rerr2), .state_dbg(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait-state access: returns during the RESP cycle.
  task automatic req0(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    addr = a; wdata = d; funct3 = f3; rd0 = rd; wr0 = wr;
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0;
  endtask

  // Two-wait-state access: returns during the RESP cycle.
  task automatic req2(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    addr = a; wdata = d; funct3 = f3; rd2 = rd; wr2 = wr;
    @(negedge clk);
    rd2 = 1'b0; wr2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_mis0", 32'(mis0), 32'd0);
    chk("rst_rerr0", 32'(rerr0), 32'd0);
    chk("rst_state0", 32'(st0), 32'd0);
    chk("rst_rdata2", rdata2, 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_state2", 32'(st2), 32'd0);
    rst0 = 1'b0; rst2 = 1'b0;

    // SW then LW, zero wait states.
    req0(1'b0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, F_W);
    chk("sw_rvalid", 32'(rvalid0), 32'd0);
    chk("sw_busy", 32'(busy0), 32'd0);
    req0(1'b1, 1'b0, 32'h0001_0004, 32'd0, F_W);
    chk("lw_rvalid", 32'(rvalid0), 32'd1);
    chk("lw_rdata", rdata0, 32'hDEAD_BEEF);
    chk("lw_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("lw_rvalid_drop", 32'(rvalid0), 32'd0);
    chk("lw_rdata_hold", rdata0, 32'hDEAD_BEEF);

    // Byte/half lanes and extension.
    req0(1'b0, 1'b1, 32'h0001_0008, 32'h0000_0000, F_W);
    req0(1'b0, 1'b1, 32'h0001_000B, 32'h0000_0080, F_B);
    req0(1'b1, 1'b0, 32'h0001_000B, 32'd0, F_B);
    chk("lb", rdata0, 32'hFFFF_FF80);
    req0(1'b1, 1'b0, 32'h0001_000B, 32'd0, F_BU);
    chk("lbu", rdata0, 32'h0000_0080);
    req0(1'b1, 1'b0, 32'h0001_0008, 32'd0, F_W);
    chk("lw_after_sb", rdata0, 32'h8000_0000);
    req0(1'b0, 1'b1, 32'h0001_000A, 32'h0000_7FFF, F_H);
    req0(1'b1, 1'b0, 32'h0001_000A, 32'd0, F_H);
    chk("lh_pos", rdata0, 32'h0000_7FFF);
    req0(1'b0, 1'b1, 32'h0001_0008, 32'hFFFF_8001, F_H);
    req0(1'b1, 1'b0, 32'h0001_0008, 32'd0, F_H);
    chk("lh_neg", rdata0, 32'hFFFF_8001);
    req0(1'b1, 1'b0, 32'h0001_0008, 32'd0, F_HU);
    chk("lhu", rdata0, 32'h0000_8001);
    req0(1'b1, 1'b0, 32'h0001_0008, 32'd0, F_W);
    chk("lw_after_sh", rdata0, 32'h7FFF_8001);
    req0(1'b1, 1'b0, 32'h0001_0008, 32'd0, 3'b111);
    chk("undef_f3_as_w", rdata0, 32'h7FFF_8001);

    // Misaligned accesses.
    req0(1'b1, 1'b0, 32'h0001_0006, 32'd0, F_W);
    chk("mis_lw_rvalid", 32'(rvalid0), 32'd1);
    chk("mis_lw_rdata", rdata0, 32'd0);
    chk("mis_lw_flag", 32'(mis0), 32'd1);
    chk("mis_lw_rerr", 32'(rerr0), 32'd0);
    req0(1'b0, 1'b1, 32'h0001_0005, 32'h0000_0000, F_H);
    chk("mis_sh_flag", 32'(mis0), 32'd1);
    chk("mis_sh_rvalid", 32'(rvalid0), 32'd0);
    req0(1'b1, 1'b0, 32'h0001_0004, 32'd0, F_W);
    chk("mis_unchanged", rdata0, 32'hDEAD_BEEF);
    chk("mis_clear", 32'(mis0), 32'd0);

    // Out of range; address 0 aliases word index 0 after truncation.
    req0(1'b0, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, F_W);
    req0(1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, F_W);
    chk("oor_sw_rerr", 32'(rerr0), 32'd1);
    chk("oor_sw_rvalid", 32'(rvalid0), 32'd0);
    req0(1'b1, 1'b0, 32'h0000_0000, 32'd0, F_W);
    chk("oor_lw_rvalid", 32'(rvalid0), 32'd1);
    chk("oor_lw_rdata", rdata0, 32'd0);
    chk("oor_lw_rerr", 32'(rerr0), 32'd1);
    req0(1'b1, 1'b0, 32'h0001_0000, 32'd0, F_W);
    chk("oor_word0_kept", rdata0, 32'hCAFE_F00D);
    req0(1'b1, 1'b0, 32'h0000_0002, 32'd0, F_W);
    chk("both_mis", 32'(mis0), 32'd1);
    chk("both_rerr", 32'(rerr0), 32'd1);
    req0(1'b0, 1'b1, 32'h0001_0FFC, 32'h0BAD_0BAD, F_W);
    chk("top_sw_rerr", 32'(rerr0), 32'd0);
    req0(1'b1, 1'b0, 32'h0001_0FFC, 32'd0, F_W);
    chk("top_lw", rdata0, 32'h0BAD_0BAD);
    req0(1'b1, 1'b0, 32'h0001_1000, 32'd0, F_W);
    chk("above_rerr", 32'(rerr0), 32'd1);
    req0(1'b1, 1'b0, 32'h0000_FFFC, 32'd0, F_W);
    chk("below_rerr", 32'(rerr0), 32'd1);

    // Both strobes: store only.
    req0(1'b1, 1'b1, 32'h0001_0010, 32'h1234_5678, F_W);
    chk("rw_no_rvalid", 32'(rvalid0), 32'd0);
    req0(1'b1, 1'b0, 32'h0001_0010, 32'd0, F_W);
    chk("rw_stored", rdata0, 32'h1234_5678);

    // Two wait states: busy window and held back-to-back request.
    req2(1'b0, 1'b1, 32'h0001_0020, 32'hAAAA_5555, F_W);
    req2(1'b0, 1'b1, 32'h0001_0024, 32'h0102_0304, F_W);
    @(negedge clk);
    addr = 32'h0001_0020; funct3 = F_W; rd2 = 1'b1;
    @(negedge clk);
    chk("ws_busy1", 32'(busy2), 32'd1);
    chk("ws_rvalid1", 32'(rvalid2), 32'd0);
    addr = 32'h0001_0024;
    @(negedge clk);
    chk("ws_busy2", 32'(busy2), 32'd1);
    chk("ws_rvalid2", 32'(rvalid2), 32'd0);
    @(negedge clk);
    chk("ws_resp_busy", 32'(busy2), 32'd0);
    chk("ws_resp_rvalid", 32'(rvalid2), 32'd1);
    chk("ws_resp_rdata", rdata2, 32'hAAAA_5555);
    @(negedge clk);
    rd2 = 1'b0;
    chk("ws_held_busy", 32'(busy2), 32'd1);
    chk("ws_held_rvalid", 32'(rvalid2), 32'd0);
    @(negedge clk);
    chk("ws_held_busy2", 32'(busy2), 32'd1);
    @(negedge clk);
    chk("ws_held_rvalid2", 32'(rvalid2), 32'd1);
    chk("ws_held_rdata", rdata2, 32'h0102_0304);

    // Reset during the WAIT of a store: store must survive.
    @(negedge clk);
    addr = 32'h0001_0030; wdata = 32'h5A5A_5A5A; funct3 = F_W; wr2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    chk("rst_st_busy_pre", 32'(busy2), 32'd1);
    #1 rst2 = 1'b1;
    #1;
    chk("rst_st_busy", 32'(busy2), 32'd0);
    chk("rst_st_state", 32'(st2), 32'd0);
    @(negedge clk);
    rst2 = 1'b0;

    // Reset during the WAIT of a read: read abandoned, rdata cleared.
    req2(1'b1, 1'b0, 32'h0001_0024, 32'd0, F_W);
    chk("rst_rd_pre_rdata", rdata2, 32'h0102_0304);
    @(negedge clk);
    addr = 32'h0001_0020; rd2 = 1'b1;
    @(negedge clk);
    rd2 = 1'b0;
    chk("rst_rd_busy_pre", 32'(busy2), 32'd1);
    #1 rst2 = 1'b1;
    #1;
    chk("rst_rd_rdata", rdata2, 32'd0);
    chk("rst_rd_busy", 32'(busy2), 32'd0);
    chk("rst_rd_rvalid", 32'(rvalid2), 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | rvalid2;
    end
    chk("rst_rd_no_rvalid", 32'(seen), 32'd0);
    req2(1'b1, 1'b0, 32'h0001_0030, 32'd0, F_W);
    chk("rst_store_kept_rvalid", 32'(rvalid2), 32'd1);
    chk("rst_store_kept", rdata2, 32'h5A5A_5A5A);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
